// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the MIPS unified-memory arbiter: FSM state encoding,
// master identifiers and wait-counter sizing.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  localparam logic MASTER_CPU    = 1'b0;
  localparam logic MASTER_LOADER = 1'b1;

  localparam int CNT_W = 3;

  // Value loaded into the wait counter so that it reaches zero in the cycle
  // where the memory read data is valid.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned latency);
    return CNT_W'(latency - 32'd1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to the master that was not granted last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  // Winner selection from the request pair and the previous grant.
  always_comb begin
    grant = MASTER_CPU;
    valid = 1'b0;
    case (req)
      2'b01: begin
        grant = MASTER_CPU;
        valid = 1'b1;
      end
      2'b10: begin
        grant = MASTER_LOADER;
        valid = 1'b1;
      end
      2'b11: begin
        grant = ~last;
        valid = 1'b1;
      end
      default: begin
        grant = MASTER_CPU;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing the multicycle MIPS unified memory between the CPU
// (master 0) and the program loader (master 1); fixed-latency access, one-cycle ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_latency_check
    $error("mem_arbiter: MEM_LATENCY must lie in 1..7");
  end

  arb_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              grant;
  logic              last_grant;
  logic              xfer_we;

  logic              pick_grant;
  logic              pick_valid;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_pick2 u_pick (
    .req   ({bus.m1_req, bus.m0_req}),
    .last  (last_grant),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Request fields of whichever master the picker selects this cycle.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (pick_grant == MASTER_LOADER) begin
      win_we    = bus.m1_we;
      win_addr  = bus.m1_addr;
      win_wdata = bus.m1_wdata;
    end else begin
      win_we    = bus.m0_we;
      win_addr  = bus.m0_addr;
      win_wdata = bus.m0_wdata;
    end
  end

  // Transaction sequencer; strobes and acks default low so each is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      grant         <= MASTER_CPU;
      last_grant    <= MASTER_LOADER;
      xfer_we       <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.m0_ack    <= 1'b0;
      bus.m1_ack    <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
    end else begin
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.m0_ack <= 1'b0;
      bus.m1_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant         <= pick_grant;
            last_grant    <= pick_grant;
            xfer_we       <= win_we;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= win_we;
            bus.mem_addr  <= win_addr;
            bus.mem_wdata <= win_wdata;
            state         <= ST_ACCESS;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          wait_cnt <= wait_load(MEM_LATENCY);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Counter hits zero exactly in the cycle mem_rdata is valid.
          if (wait_cnt == '0) begin
            if (grant == MASTER_LOADER) begin
              bus.m1_ack <= 1'b1;
              if (!xfer_we) begin
                bus.m1_rdata <= bus.mem_rdata;
              end else begin
                bus.m1_rdata <= bus.m1_rdata;
              end
            end else begin
              bus.m0_ack <= 1'b1;
              if (!xfer_we) begin
                bus.m0_rdata <= bus.mem_rdata;
              end else begin
                bus.m0_rdata <= bus.m0_rdata;
              end
            end
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
            state    <= ST_WAIT;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on latency-1 and latency-3 instances,
// then randomized traffic scored against a cycle-count model of the arbitration rules.
module tb_mem_arbiter;

  localparam logic [31:0] JUNK = 32'hDEAD_0BAD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0, m1_addr = 32'd0, m1_wdata = 32'd0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  // Requests reach only the selected instance; the other one stays idle.
  assign b1.m0_req = m0_req & ~sel;
  assign b1.m1_req = m1_req & ~sel;
  assign b3.m0_req = m0_req & sel;
  assign b3.m1_req = m1_req & sel;
  assign b1.m0_we = m0_we;     assign b3.m0_we = m0_we;
  assign b1.m0_addr = m0_addr; assign b3.m0_addr = m0_addr;
  assign b1.m0_wdata = m0_wdata; assign b3.m0_wdata = m0_wdata;
  assign b1.m1_we = m1_we;     assign b3.m1_we = m1_we;
  assign b1.m1_addr = m1_addr; assign b3.m1_addr = m1_addr;
  assign b1.m1_wdata = m1_wdata; assign b3.m1_wdata = m1_wdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  // Memory: 256 words, data valid only in the single cycle MEM_LATENCY after mem_en.
  bit          written [256];
  logic [31:0] wval [256];
  logic        v1 = 1'b0;
  logic [31:0] d1;
  logic [2:0]  v3 = 3'b000;
  logic [31:0] d3 [3];
  logic [31:0] ref_mem [256];

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'h8C01_0004 : ((32'(i) * 32'h0101_0193) ^ 32'hA5A5_5A5A);
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] i);
    return written[i] ? wval[i] : init_word(int'(i));
  endfunction

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) begin
      written[b1.mem_addr[9:2]] <= 1'b1;
      wval[b1.mem_addr[9:2]]    <= b1.mem_wdata;
    end
    if (b3.mem_en && b3.mem_we) begin
      written[b3.mem_addr[9:2]] <= 1'b1;
      wval[b3.mem_addr[9:2]]    <= b3.mem_wdata;
    end
    v1    <= b1.mem_en & ~b1.mem_we;
    d1    <= mem_word(b1.mem_addr[9:2]);
    v3    <= {v3[1:0], b3.mem_en & ~b3.mem_we};
    d3[0] <= mem_word(b3.mem_addr[9:2]);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign b1.mem_rdata = v1 ? d1 : JUNK;
  assign b3.mem_rdata = v3[2] ? d3[2] : JUNK;

  logic        o_m0_ack, o_m1_ack, o_mem_en, o_mem_we;
  logic [31:0] o_m0_rdata, o_m1_rdata, o_mem_addr, o_mem_wdata;
  assign o_m0_ack    = sel ? b3.m0_ack    : b1.m0_ack;
  assign o_m1_ack    = sel ? b3.m1_ack    : b1.m1_ack;
  assign o_mem_en    = sel ? b3.mem_en    : b1.mem_en;
  assign o_mem_we    = sel ? b3.mem_we    : b1.mem_we;
  assign o_mem_addr  = sel ? b3.mem_addr  : b1.mem_addr;
  assign o_mem_wdata = sel ? b3.mem_wdata : b1.mem_wdata;
  assign o_m0_rdata  = sel ? b3.m0_rdata  : b1.m0_rdata;
  assign o_m1_rdata  = sel ? b3.m1_rdata  : b1.m1_rdata;

  // Reference model: a grant at cycle g gives mem_en at g+1, ack at g+2+lat, free at g+3+lat.
  int          lat, free_at, g_cyc;
  logic        busy, last, g_who, g_we;
  logic [31:0] g_addr, g_wdata;
  logic [31:0] exp_rd [2];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    busy = 1'b0;
    free_at = cyc;
    last = 1'b1;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_chk++;
      if ({o_m0_ack, o_m1_ack, o_mem_en, o_mem_we} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_ctrl inst=%0d got=%b exp=0000", s, {o_m0_ack, o_m1_ack, o_mem_en, o_mem_we});
      end
      n_chk++;
      if ({o_mem_addr, o_mem_wdata, o_m0_rdata, o_m1_rdata} !== 128'd0) begin
        n_fail++;
        $display("FAIL reset_data inst=%0d got=%h/%h/%h/%h exp=0", s, o_mem_addr, o_mem_wdata, o_m0_rdata, o_m1_rdata);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_single_read();
    sel = 1'b0;
    do_reset();
    m0_we = 1'b0; m0_addr = 32'h40; m0_wdata = 32'd0; m0_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_chk++;
      if (o_mem_en !== (c == 1)) begin
        n_fail++; $display("FAIL single_mem_en cyc=%0d got=%b exp=%b", c, o_mem_en, c == 1);
      end
      if (c == 1) begin
        n_chk++;
        if (o_mem_addr !== 32'h40 || o_mem_we !== 1'b0) begin
          n_fail++; $display("FAIL single_mem_addr got=%h we=%b exp=00000040 we=0", o_mem_addr, o_mem_we);
        end
      end
      n_chk++;
      if (o_m0_ack !== (c == 3) || o_m1_ack !== 1'b0) begin
        n_fail++; $display("FAIL single_ack cyc=%0d got=%b%b exp=%b0", c, o_m0_ack, o_m1_ack, c == 3);
      end
      if (c >= 3) begin
        n_chk++;
        if (o_m0_rdata !== 32'h8C01_0004) begin
          n_fail++; $display("FAIL single_rdata cyc=%0d got=%h exp=8c010004", c, o_m0_rdata);
        end
      end
      if (o_m0_ack) m0_req = 1'b0;
    end
  endtask

  task automatic test_tie();
    sel = 1'b0;
    do_reset();
    m0_we = 1'b0; m0_addr = 32'h10; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = 32'h20; m1_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_chk++;
      if (o_mem_en !== (c == 1 || c == 5)) begin
        n_fail++; $display("FAIL tie_mem_en cyc=%0d got=%b", c, o_mem_en);
      end
      n_chk++;
      if (o_m0_ack !== (c == 3) || o_m1_ack !== (c == 7)) begin
        n_fail++; $display("FAIL tie_ack cyc=%0d got m0=%b m1=%b exp m0=%b m1=%b", c, o_m0_ack, o_m1_ack, c == 3, c == 7);
      end
      if (c == 1 || c == 5) begin
        n_chk++;
        if (o_mem_addr !== ((c == 1) ? 32'h10 : 32'h20)) begin
          n_fail++; $display("FAIL tie_addr cyc=%0d got=%h", c, o_mem_addr);
        end
      end
      if (c == 7) begin
        n_chk++;
        if (o_m0_rdata !== ref_mem[4] || o_m1_rdata !== ref_mem[8]) begin
          n_fail++; $display("FAIL tie_rdata got=%h/%h exp=%h/%h", o_m0_rdata, o_m1_rdata, ref_mem[4], ref_mem[8]);
        end
      end
      if (o_m0_ack) m0_req = 1'b0;
      if (o_m1_ack) m1_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int exp_order[4] = '{0, 1, 0, 1};
    int cnt0 = 0;
    int cnt1 = 0;
    sel = 1'b0;
    do_reset();
    m0_we = 1'b0; m0_addr = 32'h80; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = 32'hC0; m1_req = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_chk++;
      if (o_m0_ack && o_m1_ack) begin
        n_fail++; $display("FAIL b2b_dual_ack cyc=%0d got=11 exp=at most one", c);
      end
      if (o_m0_ack) begin
        order.push_back(0); cnt0++;
        n_chk++;
        if (o_m0_rdata !== ref_mem[m0_addr[9:2]]) begin
          n_fail++; $display("FAIL b2b_rdata0 got=%h exp=%h", o_m0_rdata, ref_mem[m0_addr[9:2]]);
        end
        m0_addr = m0_addr + 32'd4;
      end
      if (o_m1_ack) begin
        order.push_back(1); cnt1++;
        n_chk++;
        if (o_m1_rdata !== ref_mem[m1_addr[9:2]]) begin
          n_fail++; $display("FAIL b2b_rdata1 got=%h exp=%h", o_m1_rdata, ref_mem[m1_addr[9:2]]);
        end
        m1_addr = m1_addr + 32'd4;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    n_chk++;
    if (cnt0 != 2 || cnt1 != 2) begin
      n_fail++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", cnt0, cnt1);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= order.size() || order[i] != exp_order[i]) begin
        n_fail++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", i, (i < order.size()) ? order[i] : -1, exp_order[i]);
      end
    end
  endtask

  task automatic test_write();
    int n_en = 0;
    int n_wr = 0;
    sel = 1'b0;
    do_reset();
    m1_we = 1'b0; m1_addr = 32'h20; m1_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (o_mem_en) n_en++;
      if (o_mem_en && o_mem_we) begin
        n_wr++;
        n_chk++;
        if (c != 5 || o_mem_addr !== 32'h100 || o_mem_wdata !== 32'hDEAD_BEEF) begin
          n_fail++; $display("FAIL wr_strobe cyc=%0d got=%h/%h exp cyc=5 00000100/deadbeef", c, o_mem_addr, o_mem_wdata);
        end
      end
      n_chk++;
      if (o_m1_ack !== (c == 3 || c == 7) || o_m0_ack !== 1'b0) begin
        n_fail++; $display("FAIL wr_ack cyc=%0d got m1=%b m0=%b", c, o_m1_ack, o_m0_ack);
      end
      if (c >= 3) begin
        n_chk++;
        if (o_m1_rdata !== ref_mem[8]) begin
          n_fail++; $display("FAIL wr_rdata_hold cyc=%0d got=%h exp=%h", c, o_m1_rdata, ref_mem[8]);
        end
      end
      if (c == 3) begin
        m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'hDEAD_BEEF;
      end
      if (c == 7) m1_req = 1'b0;
    end
    ref_mem[64] = 32'hDEAD_BEEF;
    n_chk++;
    if (n_wr != 1 || n_en != 2) begin
      n_fail++; $display("FAIL wr_strobe_count got wr=%0d en=%0d exp wr=1 en=2", n_wr, n_en);
    end
  endtask

  task automatic test_reset_in_wait();
    sel = 1'b1;
    do_reset();
    m0_we = 1'b0; m0_addr = 32'h40; m0_req = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 4) begin
        n_chk++;
        if ({o_m0_ack, o_m1_ack, o_mem_en, o_mem_we} !== 4'b0000 ||
            {o_mem_addr, o_mem_wdata, o_m0_rdata, o_m1_rdata} !== 128'd0) begin
          n_fail++; $display("FAIL rstwait_outputs got ctl=%b addr=%h rd=%h exp all zero",
                             {o_m0_ack, o_m1_ack, o_mem_en, o_mem_we}, o_mem_addr, o_m0_rdata);
        end
      end
      n_chk++;
      if (o_m0_ack !== (c == 9) || o_m1_ack !== 1'b0) begin
        n_fail++; $display("FAIL rstwait_ack cyc=%0d got=%b exp=%b", c, o_m0_ack, c == 9);
      end
      n_chk++;
      if (o_mem_en !== (c == 1 || c == 5)) begin
        n_fail++; $display("FAIL rstwait_mem_en cyc=%0d got=%b", c, o_mem_en);
      end
      if (c >= 9) begin
        n_chk++;
        if (o_m0_rdata !== 32'h8C01_0004) begin
          n_fail++; $display("FAIL rstwait_rdata cyc=%0d got=%h exp=8c010004", c, o_m0_rdata);
        end
      end
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      if (o_m0_ack) m0_req = 1'b0;
    end
    m0_req = 1'b0;
  endtask

  task automatic test_random(input logic s);
    logic       w;
    logic       exp_en;
    logic [1:0] exp_ack;
    sel = s;
    lat = s ? 3 : 1;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (!m0_req || o_m0_ack) begin
        m0_req = ($urandom_range(0, 2) != 0);
        m0_we = ($urandom_range(0, 3) == 0);
        m0_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        m0_wdata = $urandom;
      end
      if (!m1_req || o_m1_ack) begin
        m1_req = ($urandom_range(0, 2) != 0);
        m1_we = ($urandom_range(0, 3) == 0);
        m1_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        m1_wdata = $urandom;
      end
      if (cyc >= free_at && (m0_req || m1_req)) begin
        w = (m0_req && m1_req) ? ~last : m1_req;
        last = w;
        busy = 1'b1;
        g_cyc = cyc;
        free_at = cyc + 3 + lat;
        g_who = w;
        g_we = w ? m1_we : m0_we;
        g_addr = w ? m1_addr : m0_addr;
        g_wdata = w ? m1_wdata : m0_wdata;
        if (g_we) ref_mem[g_addr[9:2]] = g_wdata;
      end
      tick();
      exp_en = busy && (cyc == g_cyc + 1);
      exp_ack = (busy && cyc == g_cyc + 2 + lat) ? (g_who ? 2'b10 : 2'b01) : 2'b00;
      if (exp_ack != 2'b00 && !g_we) exp_rd[g_who] = ref_mem[g_addr[9:2]];
      n_chk++;
      if ({o_m1_ack, o_m0_ack} !== exp_ack) begin
        n_fail++; $display("FAIL rnd_ack lat=%0d cyc=%0d got=%b exp=%b", lat, cyc, {o_m1_ack, o_m0_ack}, exp_ack);
      end
      n_chk++;
      if (o_mem_en !== exp_en) begin
        n_fail++; $display("FAIL rnd_mem_en lat=%0d cyc=%0d got=%b exp=%b", lat, cyc, o_mem_en, exp_en);
      end
      if (exp_en) begin
        n_chk++;
        if (o_mem_we !== g_we || o_mem_addr !== g_addr || o_mem_wdata !== g_wdata) begin
          n_fail++; $display("FAIL rnd_mem_bus lat=%0d cyc=%0d got=%b/%h/%h exp=%b/%h/%h", lat, cyc,
                             o_mem_we, o_mem_addr, o_mem_wdata, g_we, g_addr, g_wdata);
        end
      end
      n_chk++;
      if (o_m0_rdata !== exp_rd[0] || o_m1_rdata !== exp_rd[1]) begin
        n_fail++; $display("FAIL rnd_rdata lat=%0d cyc=%0d got=%h/%h exp=%h/%h", lat, cyc,
                           o_m0_rdata, o_m1_rdata, exp_rd[0], exp_rd[1]);
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_write();
    test_reset_in_wait();
    test_random(1'b0);
    test_random(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
